// File: rtl/updown_seq_decoder.sv
// updown_seq_decoder: recovers count direction from an observed up/down counter.
//
// Each cycle the sample q_in is compared with the previous sample. The step
// (q_in - prev) mod 2^WIDTH is classified as UP (+1), DOWN (-1), HOLD (0) or
// JUMP (anything else), so wrap-around counts as a legal step. After LOCK_CNT
// consecutive same-direction steps the block locks and then reports holds,
// legal reversals and illegal jumps. It also keeps a saturating error tally.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset
//   q_in     in   [WIDTH-1:0] observed count value
//   dir      out  recovered direction (1 = up), meaningful while locked
//   locked   out  direction lock established
//   hold     out  current sample equals previous sample
//   dir_chg  out  one-cycle pulse on a legal reversal while locked
//   err      out  one-cycle pulse on an illegal jump
//   err_cnt  out  [7:0] saturating count of err pulses
module updown_seq_decoder #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  output logic             dir,
  output logic             locked,
  output logic             hold,
  output logic             dir_chg,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned RUN_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [WIDTH-1:0] D_UP     = WIDTH'(1);
  localparam logic [WIDTH-1:0] D_DOWN   = '1;
  localparam logic [WIDTH-1:0] D_HOLD   = '0;
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;
  logic             run_dir;

  // Step classification of the current sample against the previous one.
  logic [WIDTH-1:0] delta_c;
  logic             step_up_c;
  logic             step_dn_c;
  logic             is_step_c;
  logic             is_hold_c;
  logic             is_jump_c;
  logic [RUN_W-1:0] run_nxt_c;

  always_comb begin
    delta_c   = q_in - prev;
    step_up_c = (delta_c == D_UP);
    step_dn_c = (delta_c == D_DOWN);
    is_step_c = step_up_c | step_dn_c;
    is_hold_c = (delta_c == D_HOLD);
    is_jump_c = ~(is_step_c | is_hold_c);
    // Extend the run on a matching step (or a fresh run); restart at 1 on a reversal.
    if ((run == '0) || (step_up_c == run_dir)) begin
      run_nxt_c = run + RUN_W'(1);
    end else begin
      run_nxt_c = RUN_W'(1);
    end
  end

  // Acquisition / lock FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_FIRST;
      prev    <= '0;
      run     <= '0;
      run_dir <= 1'b0;
      dir     <= 1'b0;
      locked  <= 1'b0;
      hold    <= 1'b0;
      dir_chg <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      prev    <= q_in;
      hold    <= 1'b0;
      dir_chg <= 1'b0;
      err     <= 1'b0;

      // The first sample after reset is never classified, so it cannot count as an error.
      if ((state != ST_FIRST) && is_jump_c && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end

      case (state)
        ST_FIRST: begin
          state <= ST_ACQ;
        end

        ST_ACQ: begin
          if (is_step_c) begin
            run_dir <= step_up_c;
            if (run_nxt_c == LOCK_RUN) begin
              state  <= ST_LOCK;
              locked <= 1'b1;
              dir    <= step_up_c;
              run    <= '0;
            end else begin
              run <= run_nxt_c;
            end
          end else if (is_hold_c) begin
            hold <= 1'b1;
          end else begin
            run <= '0;
            err <= 1'b1;
          end
        end

        ST_LOCK: begin
          if (is_step_c) begin
            if (step_up_c != dir) begin
              dir     <= step_up_c;
              dir_chg <= 1'b1;
            end
          end else if (is_hold_c) begin
            hold <= 1'b1;
          end else begin
            err    <= 1'b1;
            locked <= 1'b0;
            run    <= '0;
            state  <= ST_ACQ;
          end
        end

        default: begin
          state <= ST_FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_seq_decoder.sv
// Testbench for updown_seq_decoder: directed scenarios plus random stimulus,
// checked by a scoreboard fed from a behavioural reference model.
module tb_updown_seq_decoder;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned LOCK_CNT = 4;
  localparam int          MODV     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] q_in;
  logic             dir;
  logic             locked;
  logic             hold;
  logic             dir_chg;
  logic             err;
  logic [7:0]       err_cnt;

  always #5 clk = ~clk;

  updown_seq_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .dir     (dir),
    .locked  (locked),
    .hold    (hold),
    .dir_chg (dir_chg),
    .err     (err),
    .err_cnt (err_cnt)
  );

  typedef struct packed {
    logic       dir;
    logic       locked;
    logic       hold;
    logic       dir_chg;
    logic       err;
    logic [7:0] err_cnt;
  } resp_t;

  resp_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  bit    armed       = 1'b0;

  // Reference model state: "have we seen a sample", lock flag, run length and
  // direction, and the last sample.
  bit m_seen    = 1'b0;
  bit m_locked  = 1'b0;
  int m_run     = 0;
  bit m_run_dir = 1'b0;
  bit m_dir     = 1'b0;
  int m_prev    = 0;
  int m_errcnt  = 0;

  function automatic resp_t model_step(bit r, int q);
    resp_t o;
    int    d;
    bit    up;
    bit    down;
    bit    h;
    bit    j;
    bit    dc;
    h  = 1'b0;
    j  = 1'b0;
    dc = 1'b0;
    if (!r) begin
      m_seen = 1'b0; m_locked = 1'b0; m_run = 0; m_run_dir = 1'b0;
      m_dir = 1'b0; m_prev = 0; m_errcnt = 0;
    end else if (!m_seen) begin
      m_seen = 1'b1;
      m_prev = q;
    end else begin
      d    = (q - m_prev + MODV) % MODV;
      up   = (d == 1);
      down = (d == MODV - 1);
      h    = (d == 0);
      j    = !(up || down || h);
      if (!m_locked) begin
        if (up || down) begin
          if (m_run == 0 || up == m_run_dir) m_run = m_run + 1;
          else m_run = 1;
          m_run_dir = up;
          if (m_run == LOCK_CNT) begin
            m_locked = 1'b1;
            m_dir    = up;
            m_run    = 0;
          end
        end else if (j) begin
          m_run = 0;
        end
      end else begin
        if ((up || down) && up != m_dir) begin
          m_dir = up;
          dc    = 1'b1;
        end else if (j) begin
          m_locked = 1'b0;
          m_run    = 0;
        end
      end
      if (j && m_errcnt < 255) m_errcnt = m_errcnt + 1;
      m_prev = q;
    end
    o.dir     = m_dir;
    o.locked  = m_locked;
    o.hold    = h;
    o.dir_chg = dc;
    o.err     = j;
    o.err_cnt = 8'(m_errcnt);
    return o;
  endfunction

  // Apply one sample; the expected response is queued for the monitor.
  task automatic drive(input bit r, input int q);
    @(negedge clk);
    rst  = r;
    q_in = WIDTH'(q);
    exp_q.push_back(model_step(r, q));
    armed = 1'b1;
  endtask

  task automatic drive_seq(input int vals[$]);
    foreach (vals[i]) drive(1'b1, vals[i]);
  endtask

  // Monitor: every clock the registered outputs are checked against the queue.
  initial begin
    resp_t e;
    resp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty at %0t: output seen with no expected response", $time);
        end else begin
          e = exp_q.pop_front();
          a.dir = dir; a.locked = locked; a.hold = hold;
          a.dir_chg = dir_chg; a.err = err; a.err_cnt = err_cnt;
          vectors++;
          if (a !== e) begin
            miscompares++;
            $display("FAIL resp#%0d at %0t: dir/locked/hold/dir_chg/err/err_cnt got %b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                     vectors, $time, a.dir, a.locked, a.hold, a.dir_chg, a.err, a.err_cnt,
                     e.dir, e.locked, e.hold, e.dir_chg, e.err, e.err_cnt);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d responses outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    bit rdir;
    int op;
    rst  = 1'b0;
    q_in = '0;
    drive(1'b0, 0);
    drive(1'b0, 0);

    // Up-count lock and wrap, then legal reversal at 5.
    drive_seq('{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 5, 4});
    // Illegal jump while locked, then relock upward.
    drive_seq('{3, 2, 5, 6, 7, 0, 1});
    // Hold three cycles at 4, resume upward.
    drive_seq('{2, 3, 4, 4, 4, 4, 5});
    // Two more errors, relock, then reset mid-operation with err_cnt = 3.
    drive_seq('{1, 6, 7, 0, 1, 2, 3});
    drive(1'b0, 3);
    drive_seq('{6, 5, 4, 3, 2, 1, 0, 7});

    // Saturation: alternating 0/4 is a jump every cycle.
    drive(1'b0, 0);
    drive(1'b1, 0);
    for (int i = 0; i < 300; i++) drive(1'b1, (i % 2 == 0) ? 4 : 0);
    drive(1'b0, 0);

    // Random mix of steps, reversals, holds, jumps and occasional resets.
    cur  = 0;
    rdir = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      op = int'($urandom_range(0, 99));
      if (op < 2) begin
        cur = int'($urandom_range(0, MODV - 1));
        drive(1'b0, cur);
      end else begin
        if (op < 55) begin
          cur = rdir ? cur + 1 : cur - 1;
        end else if (op < 65) begin
          rdir = ~rdir;
          cur  = rdir ? cur + 1 : cur - 1;
        end else if (op < 80) begin
          cur = cur;
        end else begin
          cur = cur + int'($urandom_range(2, MODV - 2));
        end
        cur = (cur + MODV) % MODV;
        drive(1'b1, cur);
      end
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected responses never checked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_seq_decoder.md
# updown_seq_decoder

Sequence decoder on the receive side of the synchronous up/down counter. It samples the counter's `WIDTH`-bit output every clock and recovers the count direction, including modulo wrap-around. It declares lock after a run of consistent steps, then flags holds, legal direction reversals and illegal jumps, and keeps a saturating error tally. It sits downstream of the counter as a checker and direction-recovery block.

## Interface
- `WIDTH`, 3: width of the observed count.
- `LOCK_CNT`, 4: consecutive same-direction steps required to lock (legal range 1–15).
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `q_in`  in  `WIDTH`: count value under observation; sampled every cycle.
- `dir`  out  1: recovered direction; 1 = incrementing, 0 = decrementing. Meaningful only while `locked`=1.
- `locked`  out  1: direction lock established.
- `hold`  out  1: current sample equals the previous sample.
- `dir_chg`  out  1: one-cycle pulse on a legal reversal while locked.
- `err`  out  1: one-cycle pulse on an illegal jump.
- `err_cnt`  out  8: count of `err` pulses, saturating at 255.

## Operation
- **Step classification.** Each cycle after the first sample, compute `d = (q_in - prev) mod 2^WIDTH`.
  - `d`=1 → UP.
  - `d`=all-ones → DOWN.
  - `d`=0 → HOLD.
  - Any other value → JUMP.
  - Wrap is legal: with `WIDTH`=3, 7→0 is UP and 0→7 is DOWN.
- **`prev` register.** Loads `q_in` every non-reset cycle.
- **FSM: FIRST, ACQ, LOCK.**
  - **FIRST** (reset state): capture `prev`, move to ACQ. No outputs asserted. No classification.
  - **ACQ**:
    - UP/DOWN matching `run_dir`, or `run`=0: `run` increments and `run_dir` takes the step direction.
    - UP/DOWN opposite to `run_dir`: `run` = 1, `run_dir` flips.
    - HOLD: `run` unchanged, `hold`=1.
    - JUMP: `run` = 0, `err` pulse.
    - When the increment makes `run` equal `LOCK_CNT`: go to LOCK, `locked`=1, `dir`=`run_dir`.
  - **LOCK**:
    - Step matching `dir`: no action.
    - Opposite step: `dir` flips, `dir_chg`=1 for one cycle, stay in LOCK.
    - HOLD: `hold`=1, stay in LOCK.
    - JUMP: `err` pulse, `locked`=0, `run`=0, go to ACQ.
- **`run` counter.** 4 bits wide; cleared on entry to LOCK.
- **`err_cnt`.** Increments on every `err` pulse and holds at 255.
- **Reset.** `rst`=0 at an edge forces state FIRST and clears `run`, `run_dir`, `prev` and every output, regardless of current state.
- **Reset values.** `dir`=0, `locked`=0, `hold`=0, `dir_chg`=0, `err`=0, `err_cnt`=0.

## Timing
- All outputs are registered. The response to the `q_in` sampled at edge N appears immediately after edge N and is held until edge N+1.
- `hold`, `dir_chg` and `err` are evaluated every cycle; each is high for exactly the cycle its triggering sample was classified.
- Lock latency: the first sample after reset, plus `LOCK_CNT` consistent steps. `locked` rises at the edge sampling the `LOCK_CNT`-th step (edge `LOCK_CNT`+1 after reset release).
- A JUMP while locked drops `locked` at that same edge. The JUMP sample becomes the new `prev`, so relock needs `LOCK_CNT` more steps.
- The first sample after reset never produces `err` or `hold`, whatever its value.
- When the `counter` output `q` (registered on the same clock) drives `q_in`, each count value is seen one edge after the counter produces it. No combinational path is allowed from `q_in` to any output.

## Test plan
- **Up-count lock and wrap.** Release `rst` with `q_in` counting up 0,1,…,7,0,1 (`LOCK_CNT`=4, `WIDTH`=3) → `locked`=1 and `dir`=1 at the edge sampling 4. The 7→0 wrap gives no `err`; `err_cnt`=0.
- **Legal reversal.** While locked up at 5, drive 6,5,4 → `dir_chg` pulses one cycle on the 6→5 step. `dir`=0 from then on, `locked` stays 1, no `err`.
- **Illegal jump and relock.** While locked, drive 2→5 → `err` one cycle, `err_cnt`=1, `locked`=0. Then 6,7,0,1 → `locked`=1 at the sample of 1.
- **Hold.** While locked, hold `q_in`=4 for 3 cycles → `hold`=1 for 3 cycles, `locked` stays 1, `err`=0. Resuming at 5 (if `dir`=1) → `hold`=0 with no `dir_chg`.
- **Saturation.** After the first sample, alternate `q_in` 0,4 for 300 cycles → `err` every cycle, `err_cnt` stops at 255, `locked` stays 0.
- **Reset mid-operation.** While locked with `err_cnt`=3, drive `rst`=0 for one edge → all outputs 0 after that edge. The next sample (any value) gives no `err`; relock follows the lock-latency rule.
